// File: rtl/bram_pkg.sv
// Shared definitions for the sample-BRAM write controller.
// Contents: FSM state encoding, fill-mode constants, default geometry.
package bram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CIRC   = 1'b1;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/bram_sample_writer_if.sv
// Sample stream handshake between the upstream source and the BRAM writer.
// Signals: valid (source -> writer), data (source -> writer),
//          ready (writer -> source, registered in the writer).
// Modports: master = upstream source, slave = bram_sample_writer.
interface bram_sample_writer_if
  import bram_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/wrap_counter.sv
// Modulus-DEPTH address counter for the BRAM write port.
// Ports: clk, rst (async, active-high), clr (sync clear to 0, wins over en),
//        en (advance by one), count (current address),
//        wrap (combinational: en while count is at DEPTH-1, i.e. this
//        advance rolls the counter back to 0).
// DEPTH need not be a power of two, so the rollover is an explicit compare.
module wrap_counter #(
  parameter int DEPTH = 16,
  parameter int LEN   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [LEN-1:0] count,
  output logic           wrap
);

  localparam logic [LEN-1:0] LAST = LEN'(DEPTH - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/bram_sample_writer.sv
// Write-side controller for the sample-signal block RAM.
// Accepts samples over a valid/ready stream and writes them to sequential
// BRAM addresses, either as a single DEPTH-word fill or as a circular
// delay-line ring that runs until stopped.
// Ports:
//   i_clkwr, i_rst        write clock, async active-high reset
//   smp (slave)           sample stream: valid, data in; ready out (registered)
//   i_start, i_mode       start pulse (IDLE only), mode 0 single / 1 circular
//   i_stop                early end / end of circular run (FILL only)
//   o_wren/o_wraddr/o_datain  registered BRAM write port, one cycle after accept
//   o_busy, o_done        in FILL; one-cycle completion pulse
//   o_full, o_count       all DEPTH words written; accepted words (saturating)
//   o_chksum              running sum of accepted data when WRITER_CHKSUM_EN
//                         is defined, otherwise constant 0
//
// State | meaning
// IDLE  | waiting for i_start; stream not ready
// FILL  | accepting samples and writing them to the BRAM
// DONE  | one-cycle o_done pulse, then back to IDLE
module bram_sample_writer
  import bram_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int LEN   = $clog2(DEPTH)
) (
  input  logic                 i_clkwr,
  input  logic                 i_rst,
  bram_sample_writer_if.slave  smp,
  input  logic                 i_start,
  input  logic                 i_mode,
  input  logic                 i_stop,
  output logic                 o_wren,
  output logic [LEN-1:0]       o_wraddr,
  output logic [WIDTH-1:0]     o_datain,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_full,
  output logic [LEN:0]         o_count,
  output logic [WIDTH-1:0]     o_chksum
);

  localparam logic [LEN:0] CNT_MAX = (LEN+1)'(DEPTH);

  state_t         state_q, state_d;
  logic           mode_q;
  logic           ready_q;
  logic           accept;
  logic           start_go;
  logic           wrap;
  logic [LEN-1:0] addr;

  assign smp.ready = ready_q;
  // ready_q is only ever high while in FILL, so accept implies FILL.
  assign accept    = smp.valid && ready_q;
  assign start_go  = (state_q == IDLE) && i_start;

  wrap_counter #(.DEPTH(DEPTH), .LEN(LEN)) u_addr (
    .clk   (i_clkwr),
    .rst   (i_rst),
    .clr   (start_go),
    .en    (accept),
    .count (addr),
    .wrap  (wrap)
  );

  always_ff @(posedge i_clkwr or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Addresses start at 0, so the first wrap is exactly the DEPTH-th accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_start) state_d = FILL;
      FILL: if (i_stop || (accept && wrap && (mode_q == MODE_SINGLE))) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs follow the next state so they line up with the state itself.
  always_ff @(posedge i_clkwr or posedge i_rst) begin
    if (i_rst) begin
      ready_q  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_wren   <= 1'b0;
      o_wraddr <= '0;
      o_datain <= '0;
      o_full   <= 1'b0;
      o_count  <= '0;
      mode_q   <= MODE_SINGLE;
    end else begin
      ready_q <= (state_d == FILL);
      o_busy  <= (state_d == FILL);
      o_done  <= (state_d == DONE);
      o_wren  <= accept;
      if (accept) begin
        o_wraddr <= addr;
        o_datain <= smp.data;
      end
      if (start_go) begin
        mode_q  <= i_mode;
        o_full  <= 1'b0;
        o_count <= '0;
      end else if (accept) begin
        if (wrap) o_full <= 1'b1;
        if (o_count != CNT_MAX) o_count <= o_count + 1'b1;
      end
    end
  end

`ifdef WRITER_CHKSUM_EN
  always_ff @(posedge i_clkwr or posedge i_rst) begin
    if (i_rst) begin
      o_chksum <= '0;
    end else if (start_go) begin
      o_chksum <= '0;
    end else if (accept) begin
      o_chksum <= o_chksum + smp.data;
    end
  end
`else
  assign o_chksum = '0;
`endif

endmodule

// File: tb/tb_bram_sample_writer.sv
// Self-checking bench for bram_sample_writer (WIDTH=8, DEPTH=16).
// Expected writes are queued as each accept is driven and compared as the
// BRAM write port fires; a small memory stands in for the BRAM.
module tb_bram_sample_writer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int LEN   = 4;

  logic             i_clkwr = 1'b0;
  logic             i_rst   = 1'b1;
  logic             i_start = 1'b0;
  logic             i_mode  = 1'b0;
  logic             i_stop  = 1'b0;
  logic             o_wren;
  logic [LEN-1:0]   o_wraddr;
  logic [WIDTH-1:0] o_datain;
  logic             o_busy, o_done, o_full;
  logic [LEN:0]     o_count;
  logic [WIDTH-1:0] o_chksum;

  bram_sample_writer_if #(.WIDTH(WIDTH)) smp ();

  bram_sample_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clkwr  (i_clkwr),
    .i_rst    (i_rst),
    .smp      (smp),
    .i_start  (i_start),
    .i_mode   (i_mode),
    .i_stop   (i_stop),
    .o_wren   (o_wren),
    .o_wraddr (o_wraddr),
    .o_datain (o_datain),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_full   (o_full),
    .o_count  (o_count),
    .o_chksum (o_chksum)
  );

  always #5 i_clkwr = ~i_clkwr;

  int n_chk = 0;
  int n_err = 0;

  logic [11:0]      sb[$];
  logic [WIDTH-1:0] mem [DEPTH];
  int               exp_addr;
  int               exp_cnt;
  logic [WIDTH-1:0] exp_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stand-in for the BRAM write port.
  always @(posedge i_clkwr) if (o_wren) mem[o_wraddr] <= o_datain;

  always @(negedge i_clkwr) begin
    logic [11:0] e;
    if (!i_rst && o_wren) begin
      if (sb.size() == 0) begin
        chk("wr_unexpected", {31'd0, o_wren}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", {28'd0, o_wraddr}, {28'd0, e[11:8]});
        chk("wr_data", {24'd0, o_datain}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic start_fill(input logic m, input logic stp);
    i_start = 1'b1; i_mode = m; i_stop = stp;
    exp_addr = 0; exp_cnt = 0; exp_sum = '0;
    @(negedge i_clkwr);
    i_start = 1'b0; i_stop = 1'b0;
  endtask

  // Called at a negedge; ready is registered so its value now decides the next edge.
  task automatic send_word(input logic [7:0] d, input logic stp);
    bit ok;
    ok = 0;
    smp.valid = 1'b1; smp.data = d; i_stop = stp;
    for (int t = 0; t < 50; t++) begin
      if (smp.ready) begin
        sb.push_back({4'(exp_addr), d});
        exp_addr = (exp_addr == DEPTH - 1) ? 0 : exp_addr + 1;
        if (exp_cnt < DEPTH) exp_cnt++;
`ifdef WRITER_CHKSUM_EN
        exp_sum = exp_sum + d;
`endif
        ok = 1;
      end
      @(negedge i_clkwr);
      if (ok) break;
    end
    smp.valid = 1'b0; i_stop = 1'b0;
    if (!ok) chk("ready_timeout", {31'd0, smp.ready}, 32'd1);
  endtask

  task automatic idle_cycle();
    smp.valid = 1'b0;
    @(negedge i_clkwr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    smp.valid = 1'b0;
    smp.data  = '0;
    exp_addr = 0; exp_cnt = 0; exp_sum = '0;

    #3;
    chk("rst_ready", {31'd0, smp.ready}, 0);
    chk("rst_wren",  {31'd0, o_wren}, 0);
    chk("rst_busy",  {31'd0, o_busy}, 0);
    chk("rst_done",  {31'd0, o_done}, 0);
    chk("rst_full",  {31'd0, o_full}, 0);
    chk("rst_count", {27'd0, o_count}, 0);
    chk("rst_addr",  {28'd0, o_wraddr}, 0);
    chk("rst_chk",   {24'd0, o_chksum}, 0);
    @(negedge i_clkwr);
    i_rst = 1'b0;
    @(negedge i_clkwr);

    // stop alone in IDLE is ignored
    i_stop = 1'b1;
    @(negedge i_clkwr);
    i_stop = 1'b0;
    chk("idle_stop_busy", {31'd0, o_busy}, 0);
    chk("idle_stop_done", {31'd0, o_done}, 0);

    // single fill, back-to-back
    start_fill(1'b0, 1'b0);
    chk("fill_busy", {31'd0, o_busy}, 1);
    for (int i = 0; i < DEPTH; i++) send_word(8'(8'h10 + i), 1'b0);
    chk("fill_done",  {31'd0, o_done}, 1);
    chk("fill_ready", {31'd0, smp.ready}, 0);
    chk("fill_full",  {31'd0, o_full}, 1);
    chk("fill_count", {27'd0, o_count}, 32'(exp_cnt));
    chk("fill_chk",   {24'd0, o_chksum}, {24'd0, exp_sum});
    @(negedge i_clkwr);
    chk("fill_done_pulse", {31'd0, o_done}, 0);
    chk("fill_idle_busy",  {31'd0, o_busy}, 0);
    for (int i = 0; i < DEPTH; i++) chk("fill_readback", {24'd0, mem[i]}, 32'(8'h10 + i));
    chk("fill_sb_empty", sb.size(), 0);

    // backpressure: valid toggles 1-0-1
    start_fill(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      send_word(8'(8'h30 + i), 1'b0);
      if (i != DEPTH - 1) begin
        idle_cycle();
        chk("bp_count_hold", {27'd0, o_count}, 32'(i + 1));
      end
    end
    chk("bp_done",  {31'd0, o_done}, 1);
    chk("bp_count", {27'd0, o_count}, 16);
    @(negedge i_clkwr);
    chk("bp_sb_empty", sb.size(), 0);

    // circular wrap, with a start pulse mid-run that must be ignored
    start_fill(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) i_start = 1'b1;
      send_word(8'(i), 1'b0);
      i_start = 1'b0;
      if (i == DEPTH - 2) chk("circ_full_early", {31'd0, o_full}, 0);
    end
    chk("circ_count", {27'd0, o_count}, 32'(exp_cnt));
    chk("circ_full",  {31'd0, o_full}, 1);
    chk("circ_done_low", {31'd0, o_done}, 0);
    chk("circ_busy",  {31'd0, o_busy}, 1);
    i_stop = 1'b1;
    @(negedge i_clkwr);
    i_stop = 1'b0;
    chk("circ_stop_done", {31'd0, o_done}, 1);
    @(negedge i_clkwr);
    chk("circ_idle", {31'd0, o_busy}, 0);
    for (int i = 0; i < DEPTH; i++)
      chk("circ_readback", {24'd0, mem[i]}, (i < 4) ? 32'(8'h10 + i) : 32'(i));
    chk("circ_sb_empty", sb.size(), 0);

    // stop with the 5th accept; start+stop together in IDLE starts
    start_fill(1'b0, 1'b1);
    chk("startstop_busy", {31'd0, o_busy}, 1);
    for (int i = 1; i <= 4; i++) send_word(8'(8'hA0 + i), 1'b0);
    send_word(8'hA5, 1'b1);
    chk("stop_done",  {31'd0, o_done}, 1);
    chk("stop_count", {27'd0, o_count}, 5);
    chk("stop_full",  {31'd0, o_full}, 0);
    chk("stop_chk",   {24'd0, o_chksum}, {24'd0, exp_sum});
    @(negedge i_clkwr);
    chk("stop_done_pulse", {31'd0, o_done}, 0);
    chk("stop_sb_empty", sb.size(), 0);

    // asynchronous reset mid-fill with a write in flight
    start_fill(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_word(8'(8'hC0 + i), 1'b0);
    #1 i_rst = 1'b1;
    #1;
    chk("arst_wren",  {31'd0, o_wren}, 0);
    chk("arst_ready", {31'd0, smp.ready}, 0);
    chk("arst_busy",  {31'd0, o_busy}, 0);
    chk("arst_count", {27'd0, o_count}, 0);
    chk("arst_addr",  {28'd0, o_wraddr}, 0);
    chk("arst_data",  {24'd0, o_datain}, 0);
    chk("arst_chk",   {24'd0, o_chksum}, 0);
    sb.delete();
    @(negedge i_clkwr);
    i_rst = 1'b0;
    @(negedge i_clkwr);
    start_fill(1'b0, 1'b0);
    send_word(8'h55, 1'b0);
    send_word(8'h66, 1'b0);
    chk("restart_count", {27'd0, o_count}, 2);
    i_stop = 1'b1;
    @(negedge i_clkwr);
    i_stop = 1'b0;
    @(negedge i_clkwr);

    // checksum: 16 x 0x20 wraps to 0 (or 0 when the accumulator is absent)
    start_fill(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      send_word(8'h20, 1'b0);
      if (i == 2) chk("sum_partial", {24'd0, o_chksum}, {24'd0, exp_sum});
    end
    chk("sum_final", {24'd0, o_chksum}, {24'd0, exp_sum});
    @(negedge i_clkwr);
    @(negedge i_clkwr);
    chk("sum_hold", {24'd0, o_chksum}, {24'd0, exp_sum});
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
